mem_readout_merge: RTL

Parametrised successor to the fixed 12-input readout merger. It drains N_CH per-BX memories, each holding a known item count, into one tagged output stream. Each event opens with a BX header word. Arbitration is selectable between fixed-priority and round-robin. Downstream backpressure is supported through a valid/ready handshake. It sits between the stub/projection memories and the next processing stage's input link.

---
 rtl/mem_readout_pkg.sv | 23 ++
 rtl/readout_fifo.sv | 56 +++++
 rtl/mem_readout_merge.sv | 184 ++++++++++++++++++
 3 files changed

// File: rtl/mem_readout_pkg.sv
// Shared types and helpers for the readout merger: channel-id width,
// header channel id and the event FSM states.
package mem_readout_pkg;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_SETUP,
        ST_HEADER,
        ST_READ,
        ST_DRAIN,
        ST_DONE
    } state_e;

    // Header words carry an all-ones channel id; callers slice the low CH_W bits.
    localparam int                MAX_CH_W   = 8;
    localparam logic [MAX_CH_W-1:0] HDR_ID_ALL = '1;

    // One extra code above N_CH-1 is reserved so the header id never aliases a channel.
    function automatic int ch_w(input int n_ch);
        return $clog2(n_ch + 1);
    endfunction

endpackage

// File: rtl/readout_fifo.sv
// Synchronous FIFO with flush. The output is taken from storage flops, so a word
// written in cycle t is visible at cycle t+1.
module readout_fifo #(
    parameter int WIDTH = 45,
    parameter int DEPTH = 4,
    parameter int CNT_W = $clog2(DEPTH + 1)
) (
    input  logic             clk,
    input  logic             reset_n,
    input  logic             flush_i,
    input  logic             wr_en_i,
    input  logic [WIDTH-1:0] wr_data_i,
    input  logic             rd_en_i,
    output logic [WIDTH-1:0] rd_data_o,
    output logic [CNT_W-1:0] count_o
);

    localparam int PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;

    logic [WIDTH-1:0] mem_q [DEPTH];
    logic [PTR_W-1:0] wr_ptr_q;
    logic [PTR_W-1:0] rd_ptr_q;
    logic [CNT_W-1:0] count_q;
    logic             push;
    logic             pop;

    function automatic logic [PTR_W-1:0] ptr_inc(input logic [PTR_W-1:0] p);
        return (p == PTR_W'(DEPTH - 1)) ? '0 : p + 1'b1;
    endfunction

    assign push = wr_en_i && (count_q != CNT_W'(DEPTH));
    assign pop  = rd_en_i && (count_q != '0);

    // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
    always_ff @(posedge clk) begin
        if (!reset_n || flush_i) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            if (push) wr_ptr_q <= ptr_inc(wr_ptr_q);
            if (pop)  rd_ptr_q <= ptr_inc(rd_ptr_q);
            if (push && !pop)      count_q <= count_q + 1'b1;
            else if (pop && !push) count_q <= count_q - 1'b1;
        end
    end

    // NOTE: storage is deliberately not reset; count_q alone says which entries are live.
    always_ff @(posedge clk) begin
        if (push) mem_q[wr_ptr_q] <= wr_data_i;
    end

    assign rd_data_o = mem_q[rd_ptr_q];
    assign count_o   = count_q;

endmodule

// File: rtl/mem_readout_merge.sv
// Drains N_CH per-BX memories into one tagged stream: a BX header, then
// {ch_id, payload} words, arbitrated fixed-priority or round-robin.
module mem_readout_merge
    import mem_readout_pkg::*;
#(
    parameter int N_CH    = 12,
    parameter int DATA_W  = 40,
    parameter int ADDR_W  = 6,
    parameter int CNT_W   = 7,
    parameter int BX_W    = 3,
    parameter int RD_LAT  = 2,
    parameter int RR_MODE = 0
) (
    input  logic                          clk,
    input  logic                          reset_n,
    input  logic                          start,
    input  logic [BX_W-1:0]               bx,
    input  logic [N_CH*CNT_W-1:0]         nitems,
    output logic [N_CH-1:0]               rd_en,
    output logic [N_CH*ADDR_W-1:0]        rd_addr,
    input  logic [N_CH*DATA_W-1:0]        rd_data,
    output logic [ch_w(N_CH)+DATA_W-1:0]  out_data,
    output logic                          out_valid,
    input  logic                          out_ready,
    output logic                          out_hdr,
    output logic                          done,
    output logic                          truncated
);

    localparam int CH_W   = ch_w(N_CH);
    localparam int DEPTH  = RD_LAT + 2;
    localparam int FW     = CH_W + DATA_W + 1;
    localparam int FCNT_W = $clog2(DEPTH + 1);
    localparam int INF_W  = $clog2(RD_LAT + 1);
    localparam int REM_W  = ADDR_W + 1;
    localparam int MAX_N  = 1 << ADDR_W;
    localparam logic [CH_W-1:0] HDR_ID = HDR_ID_ALL[CH_W-1:0];

    state_e            state_q, state_d;
    logic [REM_W-1:0]  rem_q   [N_CH];
    logic [ADDR_W-1:0] addr_q  [N_CH];
    logic [BX_W-1:0]   bx_q;
    logic              epoch_q;
    logic [CH_W-1:0]   last_q;
    logic              trunc_q;
    logic              pipe_vld_q [RD_LAT];
    logic [CH_W-1:0]   pipe_ch_q  [RD_LAT];
    logic              pipe_ep_q  [RD_LAT];

    logic              any_rem;
    logic              sel_found;
    logic [CH_W-1:0]   sel_ch;
    logic [INF_W-1:0]  inflight;
    logic              issue;
    logic              ret_vld;
    logic [DATA_W-1:0] ret_data;
    logic              abort;
    logic              fifo_wr;
    logic [FW-1:0]     fifo_wdata;
    logic [FW-1:0]     fifo_rdata;
    logic [FCNT_W-1:0] fifo_cnt;

    // NOTE: every always_comb output gets a default first so no path can infer a latch.
    always_comb begin
        any_rem   = 1'b0;
        sel_found = 1'b0;
        sel_ch    = '0;
        for (int i = 0; i < N_CH; i++) begin
            int idx;
            idx = (RR_MODE != 0) ? (int'(last_q) + 1 + i) % N_CH : i;
            if (rem_q[idx] != '0) begin
                any_rem = 1'b1;
                if (!sel_found) begin
                    sel_found = 1'b1;
                    sel_ch    = CH_W'(idx);
                end
            end
        end
        inflight = '0;
        for (int s = 0; s < RD_LAT; s++) inflight += INF_W'(pipe_vld_q[s]);
        // Reads in flight already own FIFO slots, so the credit check counts them.
        issue = (state_q == ST_READ) && sel_found && !start
             && ((int'(fifo_cnt) + int'(inflight)) < DEPTH);
        ret_vld  = pipe_vld_q[RD_LAT-1] && (pipe_ep_q[RD_LAT-1] == epoch_q);
        ret_data = '0;
        for (int k = 0; k < N_CH; k++) begin
            rd_en[k] = issue && (sel_ch == CH_W'(k));
            rd_addr[k*ADDR_W +: ADDR_W] = addr_q[k];
            if (pipe_ch_q[RD_LAT-1] == CH_W'(k)) ret_data = rd_data[k*DATA_W +: DATA_W];
        end
        abort = (state_q inside {ST_SETUP, ST_HEADER, ST_READ, ST_DRAIN})
             && (any_rem || (inflight != '0) || (fifo_cnt != '0));
        fifo_wr    = (state_q == ST_HEADER) || ret_vld;
        fifo_wdata = (state_q == ST_HEADER) ? {1'b1, HDR_ID, DATA_W'(bx_q)}
                                            : {1'b0, pipe_ch_q[RD_LAT-1], ret_data};
    end

    always_comb begin
        state_d = state_q;
        unique case (state_q)
            ST_IDLE:   state_d = ST_IDLE;
            ST_SETUP:  state_d = ST_HEADER;
            ST_HEADER: if (fifo_cnt != FCNT_W'(DEPTH)) state_d = any_rem ? ST_READ : ST_DRAIN;
            ST_READ:   if (!any_rem) state_d = ST_DRAIN;
            // Look one pop ahead so done rises the cycle after the last transfer.
            ST_DRAIN:  if ((inflight == '0) && ((fifo_cnt == '0) ||
                           ((fifo_cnt == FCNT_W'(1)) && out_ready))) state_d = ST_DONE;
            ST_DONE:   state_d = ST_DONE;
            default:   state_d = ST_IDLE;
        endcase
        if (start) state_d = ST_SETUP;
    end

    always_ff @(posedge clk) begin
        if (!reset_n) begin
            state_q <= ST_IDLE;
            bx_q    <= '0;
            epoch_q <= 1'b0;
            last_q  <= CH_W'(N_CH - 1);
            trunc_q <= 1'b0;
            for (int k = 0; k < N_CH; k++) begin
                rem_q[k]  <= '0;
                addr_q[k] <= '0;
            end
            for (int s = 0; s < RD_LAT; s++) begin
                pipe_vld_q[s] <= 1'b0;
                pipe_ch_q[s]  <= '0;
                pipe_ep_q[s]  <= 1'b0;
            end
        end else begin
            state_q       <= state_d;
            trunc_q       <= start && abort;
            pipe_vld_q[0] <= issue;
            pipe_ch_q[0]  <= sel_ch;
            pipe_ep_q[0]  <= epoch_q;
            for (int s = 1; s < RD_LAT; s++) begin
                pipe_vld_q[s] <= pipe_vld_q[s-1];
                pipe_ch_q[s]  <= pipe_ch_q[s-1];
                pipe_ep_q[s]  <= pipe_ep_q[s-1];
            end
            // Event context is captured on the start edge so it is in place during SETUP.
            if (start) begin
                bx_q    <= bx;
                epoch_q <= ~epoch_q;
                last_q  <= CH_W'(N_CH - 1);
                for (int k = 0; k < N_CH; k++) begin
                    addr_q[k] <= '0;
                    rem_q[k]  <= (int'(nitems[k*CNT_W +: CNT_W]) > MAX_N) ? REM_W'(MAX_N)
                                 : REM_W'(nitems[k*CNT_W +: CNT_W]);
                end
            end else if (issue) begin
                last_q <= sel_ch;
                for (int k = 0; k < N_CH; k++) begin
                    if (sel_ch == CH_W'(k)) begin
                        addr_q[k] <= addr_q[k] + 1'b1;
                        rem_q[k]  <= rem_q[k] - 1'b1;
                    end
                end
            end
        end
    end

    readout_fifo #(
        .WIDTH (FW),
        .DEPTH (DEPTH),
        .CNT_W (FCNT_W)
    ) u_fifo (
        .clk       (clk),
        .reset_n   (reset_n),
        .flush_i   (state_q == ST_SETUP),
        .wr_en_i   (fifo_wr),
        .wr_data_i (fifo_wdata),
        .rd_en_i   (out_ready),
        .rd_data_o (fifo_rdata),
        .count_o   (fifo_cnt)
    );

    assign out_valid = (fifo_cnt != '0);
    assign out_data  = out_valid ? fifo_rdata[FW-2:0] : '0;
    assign out_hdr   = out_valid && fifo_rdata[FW-1];
    assign done      = (state_q == ST_DONE);
    assign truncated = trunc_q;

endmodule
